// File: rtl/sad_window_disp.sv
// ---------------------------------------------------------------------------
// sad_window_disp
//
// Block-matching disparity engine for a single centre pixel. For each
// candidate disparity d it streams a WxW window from the left and right
// pixel BRAMs (right window offset d columns to the left), accumulates the
// sum of absolute differences and keeps the smallest SAD seen. A request
// whose window would leave the image, or that asks for an unsupported
// window size, is rejected without touching the BRAMs.
//
// Ports:
//   clka            sole clock, rising edge
//   reset           synchronous, active-high
//   go              start request, only looked at while idle
//   window          3'b011 / 3'b101 / 3'b111 selects 3x3 / 5x5 / 7x7
//   row, col        centre pixel, captured together with go
//   l_en, l_addr    left BRAM read port (data returns one cycle later)
//   l_dout          left BRAM read data
//   r_en, r_addr    right BRAM read port (data returns one cycle later)
//   r_dout          right BRAM read data
//   busy            high while a request is being worked on
//   done            one-cycle pulse, result outputs just updated
//   err             qualifies done: request was rejected
//   disp, min_sad   best disparity and its SAD, held until the next done
// ---------------------------------------------------------------------------
module sad_window_disp #(
  parameter int PIX_W    = 8,
  parameter int IMG_COLS = 640,
  parameter int IMG_ROWS = 480,
  parameter int ADDR_W   = 32,
  parameter int MAX_DISP = 64,
  parameter int DISP_W   = 6,
  parameter int SAD_W    = 14
) (
  input  logic              clka,
  input  logic              reset,
  input  logic              go,
  input  logic [2:0]        window,
  input  logic [11:0]       row,
  input  logic [11:0]       col,
  output logic              l_en,
  output logic [ADDR_W-1:0] l_addr,
  input  logic [PIX_W-1:0]  l_dout,
  output logic              r_en,
  output logic [ADDR_W-1:0] r_addr,
  input  logic [PIX_W-1:0]  r_dout,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DISP_W-1:0] disp,
  output logic [SAD_W-1:0]  min_sad
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_DRAIN, S_CMP, S_DONE
  } state_t;

  localparam logic [31:0] ROW_LAST  = 32'(IMG_ROWS - 1);
  localparam logic [31:0] COL_LAST  = 32'(IMG_COLS - 1);
  localparam logic [31:0] DISP_LAST = 32'(MAX_DISP - 1);

  state_t              state;
  logic [2:0]          win_r;
  logic [11:0]         row_r, col_r;
  logic [2:0]          wr, wc;
  logic [DISP_W-1:0]   d, nd_last, best_d;
  logic [SAD_W-1:0]    acc, best_sad;
  logic                rd_vld, rej;

  logic [1:0]          h;
  logic                win_ok, in_range;
  logic [2:0]          wmax;
  logic [31:0]         row32, col32, h32, col_off;
  logic [DISP_W-1:0]   nd_last_c;
  logic [2:0]          nwr, nwc;
  logic [DISP_W-1:0]   ndisp;
  logic [ADDR_W-1:0]   nxt_l_addr, nxt_r_addr;
  logic [PIX_W-1:0]    diff;
  logic                issue_last;

  // Half-width of the selected window; unsupported codes leave win_ok low.
  always_comb begin
    h      = 2'd0;
    win_ok = 1'b0;
    case (win_r)
      3'b011:  begin h = 2'd1; win_ok = 1'b1; end
      3'b101:  begin h = 2'd2; win_ok = 1'b1; end
      3'b111:  begin h = 2'd3; win_ok = 1'b1; end
      default: ;
    endcase
  end

  assign wmax     = {h, 1'b0};
  assign row32    = 32'(row_r);
  assign col32    = 32'(col_r);
  assign h32      = 32'(h);
  assign in_range = (row32 >= h32) && (row32 + h32 <= ROW_LAST) &&
                    (col32 >= h32) && (col32 + h32 <= COL_LAST);

  // Last candidate is min(MAX_DISP, col-h+1)-1, so the right window never
  // reaches a column left of 0.
  assign col_off   = col32 - h32;
  assign nd_last_c = (col_off > DISP_LAST) ? DISP_W'(MAX_DISP - 1)
                                           : col_off[DISP_W-1:0];

  // Window coordinates of the read pair issued on the next cycle; the
  // addresses are registered so the BRAM sees clean flop outputs.
  always_comb begin
    nwr   = wr;
    nwc   = wc;
    ndisp = d;
    case (state)
      S_LOAD: begin
        nwr   = 3'd0;
        nwc   = 3'd0;
        ndisp = '0;
      end
      S_CMP: begin
        nwr   = 3'd0;
        nwc   = 3'd0;
        ndisp = d + 1'b1;
      end
      S_ISSUE: begin
        if (wc == wmax) begin
          nwc = 3'd0;
          nwr = wr + 3'd1;
        end else begin
          nwc = wc + 3'd1;
        end
      end
      default: ;
    endcase
  end

  assign nxt_l_addr = (ADDR_W'(row_r) - ADDR_W'(h) + ADDR_W'(nwr)) * ADDR_W'(IMG_COLS)
                    + ADDR_W'(col_r) - ADDR_W'(h) + ADDR_W'(nwc);
  assign nxt_r_addr = nxt_l_addr - ADDR_W'(ndisp);

  assign issue_last = (wr == wmax) && (wc == wmax);
  assign diff       = (l_dout >= r_dout) ? (l_dout - r_dout) : (r_dout - l_dout);

  // Main sequencer. rd_vld trails l_en by one cycle and marks the cycle in
  // which BRAM data is present, so the last pair lands during DRAIN.
  always_ff @(posedge clka) begin
    if (reset) begin
      state    <= S_IDLE;
      win_r    <= '0;
      row_r    <= '0;
      col_r    <= '0;
      wr       <= '0;
      wc       <= '0;
      d        <= '0;
      nd_last  <= '0;
      best_d   <= '0;
      acc      <= '0;
      best_sad <= '0;
      rd_vld   <= 1'b0;
      rej      <= 1'b0;
      l_en     <= 1'b0;
      r_en     <= 1'b0;
      l_addr   <= '0;
      r_addr   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      disp     <= '0;
      min_sad  <= '0;
    end else begin
      done   <= 1'b0;
      rd_vld <= l_en;
      if (rd_vld) acc <= acc + {{(SAD_W-PIX_W){1'b0}}, diff};

      case (state)
        S_IDLE: begin
          if (go) begin
            win_r <= window;
            row_r <= row;
            col_r <= col;
            busy  <= 1'b1;
            state <= S_LOAD;
          end
        end

        S_LOAD: begin
          wr       <= '0;
          wc       <= '0;
          d        <= '0;
          acc      <= '0;
          best_sad <= '1;
          best_d   <= '0;
          if (win_ok && in_range) begin
            rej     <= 1'b0;
            nd_last <= nd_last_c;
            l_en    <= 1'b1;
            r_en    <= 1'b1;
            l_addr  <= nxt_l_addr;
            r_addr  <= nxt_r_addr;
            state   <= S_ISSUE;
          end else begin
            rej   <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end
        end

        S_ISSUE: begin
          wr <= nwr;
          wc <= nwc;
          if (issue_last) begin
            l_en  <= 1'b0;
            r_en  <= 1'b0;
            state <= S_DRAIN;
          end else begin
            l_addr <= nxt_l_addr;
            r_addr <= nxt_r_addr;
          end
        end

        S_DRAIN: state <= S_CMP;

        // Strict less-than keeps the smallest disparity on ties.
        S_CMP: begin
          if (acc < best_sad) begin
            best_sad <= acc;
            best_d   <= d;
          end
          acc <= '0;
          if (d == nd_last) begin
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            d      <= ndisp;
            wr     <= '0;
            wc     <= '0;
            l_en   <= 1'b1;
            r_en   <= 1'b1;
            l_addr <= nxt_l_addr;
            r_addr <= nxt_r_addr;
            state  <= S_ISSUE;
          end
        end

        S_DONE: begin
          done    <= 1'b1;
          disp    <= best_d;
          min_sad <= best_sad;
          err     <= rej;
          state   <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sad_window_disp.sv
// ---------------------------------------------------------------------------
// tb_sad_window_disp
//
// Directed bench for sad_window_disp. Pixel BRAMs are modelled as functions
// of the address so that the right image is a known shift of the left one;
// expected results are queued when a request is issued and compared when
// done pulses.
// ---------------------------------------------------------------------------
module tb_sad_window_disp;

  localparam int PIX_W    = 8;
  localparam int IMG_COLS = 640;
  localparam int IMG_ROWS = 480;
  localparam int ADDR_W   = 32;
  localparam int MAX_DISP = 64;
  localparam int DISP_W   = 6;
  localparam int SAD_W    = 14;

  logic              clka = 1'b0;
  logic              reset;
  logic              go;
  logic [2:0]        window;
  logic [11:0]       row, col;
  logic              l_en, r_en;
  logic [ADDR_W-1:0] l_addr, r_addr;
  logic [PIX_W-1:0]  l_dout, r_dout;
  logic              busy, done, err;
  logic [DISP_W-1:0] disp;
  logic [SAD_W-1:0]  min_sad;

  sad_window_disp #(
    .PIX_W(PIX_W), .IMG_COLS(IMG_COLS), .IMG_ROWS(IMG_ROWS), .ADDR_W(ADDR_W),
    .MAX_DISP(MAX_DISP), .DISP_W(DISP_W), .SAD_W(SAD_W)
  ) dut (
    .clka(clka), .reset(reset), .go(go), .window(window), .row(row), .col(col),
    .l_en(l_en), .l_addr(l_addr), .l_dout(l_dout),
    .r_en(r_en), .r_addr(r_addr), .r_dout(r_dout),
    .busy(busy), .done(done), .err(err), .disp(disp), .min_sad(min_sad)
  );

  always #5 clka = ~clka;

  typedef struct {
    logic [DISP_W-1:0] disp;
    logic [SAD_W-1:0]  sad;
    logic              err;
    int                lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   read_cnt = 0;
  int   wrap_cnt = 0;
  int   t_go = 0;
  int   mode = 0;
  int   shift = 0;

  // Cheap address hash used as a pseudo-random image.
  function automatic logic [7:0] hash(input logic [31:0] a);
    logic [31:0] x;
    x = a * 32'h9E37_79B1;
    x = x ^ (x >> 15);
    return x[7:0];
  endfunction

  function automatic logic [7:0] lpix(input logic [31:0] a);
    case (mode)
      1:       return hash(a);
      2:       return 8'hFF;
      3:       return hash(a) & 8'h7F;
      default: return 8'h80;
    endcase
  endfunction

  function automatic logic [7:0] rpix(input logic [31:0] a);
    case (mode)
      1:       return hash(a + 32'(shift));
      2:       return 8'h00;
      3:       return (hash(a + 32'(shift)) & 8'h7F) + 8'd1;
      default: return 8'h80;
    endcase
  endfunction

  // BRAM models plus read counting and a check that the right read never
  // wraps back into the previous image row.
  always @(posedge clka) begin
    cyc <= cyc + 1;
    if (l_en) begin
      l_dout   <= lpix(l_addr);
      read_cnt <= read_cnt + 1;
    end
    if (r_en) begin
      r_dout <= rpix(r_addr);
      if ((l_addr - r_addr) > (l_addr % IMG_COLS)) wrap_cnt <= wrap_cnt + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] w, input int r, input int c,
                               input logic [DISP_W-1:0] edisp, input logic [SAD_W-1:0] esad,
                               input logic eerr, input int elat);
    exp_t e;
    e.disp = edisp; e.sad = esad; e.err = eerr; e.lat = elat;
    sb.push_back(e);
    window = w;
    row    = 12'(r);
    col    = 12'(c);
    go     = 1'b1;
    @(posedge clka); #1;
    t_go = cyc;
    go   = 1'b0;
    chk("busy_after_go", 32'(busy), 32'd1);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (done !== 1'b1 && n < 5000) begin
      @(posedge clka); #1;
      n++;
    end
    e = sb.pop_front();
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    if (done === 1'b1) begin
      chk({tag, "_latency"}, 32'(cyc - t_go), 32'(e.lat));
      chk({tag, "_disp"},    32'(disp),       32'(e.disp));
      chk({tag, "_min_sad"}, 32'(min_sad),    32'(e.sad));
      chk({tag, "_err"},     32'(err),        32'(e.err));
      @(posedge clka); #1;
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
      chk({tag, "_busy_idle"},  32'(busy), 32'd0);
    end
  endtask

  initial begin
    int rd0;
    reset = 1'b1; go = 1'b0; window = 3'b011; row = '0; col = '0;
    repeat (3) @(posedge clka);
    #1;
    chk("rst_l_en", 32'(l_en), 32'd0);
    chk("rst_r_en", 32'(r_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err",  32'(err),  32'd0);
    chk("rst_disp", 32'(disp), 32'd0);
    chk("rst_sad",  32'(min_sad), 32'd0);
    reset = 1'b0;
    @(posedge clka); #1;

    $display("[TB] 3x3 random image, shift 5");
    mode = 1; shift = 5; rd0 = read_cnt;
    applyStimulus(3'b011, 100, 200, 6'd5, 14'd0, 1'b0, 706);
    checkOutput("shift5");
    chk("shift5_reads", 32'(read_cnt - rd0), 32'd576);

    $display("[TB] 7x7 uniform image");
    mode = 0;
    applyStimulus(3'b111, 50, 300, 6'd0, 14'd0, 1'b0, 3266);
    checkOutput("uniform");

    $display("[TB] left-edge clamp");
    mode = 1; shift = 2; rd0 = read_cnt;
    applyStimulus(3'b011, 20, 4, 6'd2, 14'd0, 1'b0, 46);
    checkOutput("clamp");
    chk("clamp_reads", 32'(read_cnt - rd0), 32'd36);
    chk("clamp_no_wrap", 32'(wrap_cnt), 32'd0);

    $display("[TB] rejected requests");
    rd0 = read_cnt;
    applyStimulus(3'b100, 100, 200, 6'd0, 14'h3FFF, 1'b1, 2);
    checkOutput("rej_window");
    applyStimulus(3'b101, 1, 200, 6'd0, 14'h3FFF, 1'b1, 2);
    checkOutput("rej_row");
    applyStimulus(3'b011, 100, 639, 6'd0, 14'h3FFF, 1'b1, 2);
    checkOutput("rej_col");
    chk("rej_reads", 32'(read_cnt - rd0), 32'd0);

    $display("[TB] 7x7 saturating difference");
    mode = 2;
    applyStimulus(3'b111, 100, 300, 6'd0, 14'd12495, 1'b0, 3266);
    checkOutput("saturate");

    $display("[TB] 5x5 random image, shift 3, clamped range");
    mode = 1; shift = 3;
    applyStimulus(3'b101, 10, 20, 6'd3, 14'd0, 1'b0, 515);
    checkOutput("shift3");

    $display("[TB] 3x3 offset image, nonzero minimum");
    mode = 3; shift = 7;
    applyStimulus(3'b011, 200, 400, 6'd7, 14'd9, 1'b0, 706);
    checkOutput("offset7");

    $display("[TB] reset during ISSUE");
    mode = 1; shift = 5;
    applyStimulus(3'b011, 100, 200, 6'd5, 14'd0, 1'b0, 706);
    repeat (50) @(posedge clka);
    #1;
    reset = 1'b1;
    @(posedge clka); #1;
    reset = 1'b0;
    void'(sb.pop_back());
    chk("midrst_l_en", 32'(l_en), 32'd0);
    chk("midrst_r_en", 32'(r_en), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_disp", 32'(disp), 32'd0);
    chk("midrst_sad",  32'(min_sad), 32'd0);
    chk("midrst_err",  32'(err), 32'd0);
    applyStimulus(3'b011, 100, 200, 6'd5, 14'd0, 1'b0, 706);
    checkOutput("rerun");
    chk("final_no_wrap", 32'(wrap_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
